// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM PIN entry stage and atm_fsm.
// Holds the session state enum and default PIN geometry.
package atm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      CHECK,
      GRANTED,
      DENIED,
      LOCKED
   } pin_state_t;

   localparam int BCD_MAX          = 9;
   localparam int PIN_DIGITS_DEF   = 4;
   localparam int MAX_ATTEMPTS_DEF = 3;

   function automatic logic is_bcd(input logic [3:0] d);
      return d <= 4'(BCD_MAX);
   endfunction

endpackage

// File: rtl/atm_pin_entry_if.sv
// Keypad/card/control bundle between the keypad front end and the PIN stage.
// The master drives the keypad and session inputs; the slave reports status.
interface atm_pin_entry_if
   import atm_pkg::*;
#(
   parameter int PIN_DIGITS = PIN_DIGITS_DEF
);

   logic                    card_inserted;
   logic [4*PIN_DIGITS-1:0] stored_pin;
   logic                    key_valid;
   logic [3:0]              key_digit;
   logic                    key_enter;
   logic                    key_clear;
   logic                    session_end;
   logic                    admin_unlock;
   logic                    pin_correct;
   logic                    pin_wrong;
   logic                    card_locked;
   logic                    timeout;
   logic [1:0]              attempts_left;
   logic                    busy;

   modport master (
      output card_inserted, stored_pin,
      output key_valid, key_digit,
      output key_enter, key_clear,
      output session_end, admin_unlock,
      input  pin_correct, pin_wrong,
      input  card_locked, timeout,
      input  attempts_left, busy
   );

   modport slave (
      input  card_inserted, stored_pin,
      input  key_valid, key_digit,
      input  key_enter, key_clear,
      input  session_end, admin_unlock,
      output pin_correct, pin_wrong,
      output card_locked, timeout,
      output attempts_left, busy
   );

endinterface

// File: rtl/atm_pin_buffer.sv
// Digit shift register for PIN entry: first digit ends up most significant.
// clear wins over push; a push while full is dropped.
module atm_pin_buffer
   import atm_pkg::*;
#(
   parameter  int PIN_DIGITS = PIN_DIGITS_DEF,
   localparam int CW         = $clog2(PIN_DIGITS + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    push,
   input  logic [3:0]              digit,
   output logic [4*PIN_DIGITS-1:0] pin_buf,
   output logic [CW-1:0]           count,
   output logic                    full
);

   localparam int BW = 4 * PIN_DIGITS;

   assign full = (count == CW'(PIN_DIGITS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pin_buf <= '0;
         count   <= '0;
      end else if (clear) begin
         pin_buf <= '0;
         count   <= '0;
      end else if (push && !full) begin
         pin_buf <= BW'({pin_buf, digit});
         count   <= count + CW'(1);
      end
   end

endmodule

// File: rtl/atm_pin_entry.sv
// PIN entry stage: collects keypad digits, checks them against the card PIN,
// counts failures towards lockout and aborts idle sessions.
module atm_pin_entry
   import atm_pkg::*;
#(
   parameter int PIN_DIGITS     = PIN_DIGITS_DEF,
   parameter int MAX_ATTEMPTS   = MAX_ATTEMPTS_DEF,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input logic              clk,
   input logic              rst,
   atm_pin_entry_if.slave   bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int FW = $clog2(MAX_ATTEMPTS + 1);
   localparam int CW = $clog2(PIN_DIGITS + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [FW-1:0] F_MAX  = FW'(MAX_ATTEMPTS);

   pin_state_t              state, state_nxt;
   logic [TW-1:0]           timer, timer_nxt;
   logic [FW-1:0]           fail, fail_nxt;
   logic                    timeout_q, timeout_nxt;
   logic                    buf_clear, buf_push;
   logic [4*PIN_DIGITS-1:0] pin_buf;
   logic [CW-1:0]           count;
   logic                    full;

   atm_pin_buffer #(.PIN_DIGITS(PIN_DIGITS)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .clear   (buf_clear),
      .push    (buf_push),
      .digit   (bus.key_digit),
      .pin_buf (pin_buf),
      .count   (count),
      .full    (full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         fail      <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         fail      <= fail_nxt;
         timeout_q <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      fail_nxt    = fail;
      timeout_nxt = 1'b0;
      buf_clear   = 1'b0;
      buf_push    = 1'b0;
      unique case (state)
         IDLE: begin
            buf_clear = 1'b1;
            timer_nxt = '0;
            if (bus.card_inserted) state_nxt = COLLECT;
         end
         COLLECT: begin
            if (bus.session_end) begin
               state_nxt = IDLE;
               buf_clear = 1'b1;
            end else if (bus.key_clear) begin
               buf_clear = 1'b1;
               timer_nxt = '0;
            end else if (bus.key_enter) begin
               timer_nxt = '0;
               state_nxt = (count == CW'(PIN_DIGITS))
                         ? CHECK : DENIED;
            end else if (bus.key_valid && !full &&
                         is_bcd(bus.key_digit)) begin
               buf_push  = 1'b1;
               timer_nxt = '0;
            end else if (timer == T_LAST) begin
               state_nxt   = IDLE;
               timeout_nxt = 1'b1;
               buf_clear   = 1'b1;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         CHECK: begin
            if (bus.session_end) begin
               state_nxt = IDLE;
               buf_clear = 1'b1;
            end else if (pin_buf == bus.stored_pin) begin
               state_nxt = GRANTED;
               fail_nxt  = '0;
            end else begin
               state_nxt = DENIED;
            end
         end
         GRANTED: begin
            buf_clear = 1'b1;
            if (bus.session_end) state_nxt = IDLE;
         end
         DENIED: begin
            // lockout outranks session_end so ejecting cannot dodge it
            buf_clear = 1'b1;
            timer_nxt = '0;
            fail_nxt  = (fail == F_MAX) ? fail : fail + FW'(1);
            if (fail_nxt == F_MAX)    state_nxt = LOCKED;
            else if (bus.session_end) state_nxt = IDLE;
            else                      state_nxt = COLLECT;
         end
         LOCKED: begin
            buf_clear = 1'b1;
            if (bus.admin_unlock) begin
               fail_nxt  = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.pin_correct   = (state == GRANTED);
   assign bus.pin_wrong     = (state == DENIED);
   assign bus.card_locked   = (state == LOCKED);
   assign bus.busy          = (state == COLLECT) || (state == CHECK);
   assign bus.timeout       = timeout_q;
   assign bus.attempts_left = 2'(F_MAX - fail);

endmodule

// File: tb/tb_atm_pin_entry.sv
// Bench for atm_pin_entry: fixed vector table, directed corner sequences
// and random keypad traffic against a queue-based session model.
module tb_atm_pin_entry;

   localparam int PD = 4;
   localparam int MA = 3;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   atm_pin_entry_if #(.PIN_DIGITS(PD)) bus ();

   atm_pin_entry #(
      .PIN_DIGITS     (PD),
      .MAX_ATTEMPTS   (MA),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef enum int {
      M_IDLE, M_COLLECT, M_CHECK,
      M_GRANTED, M_DENIED, M_LOCKED
   } mph_t;

   mph_t m_ph;
   int   m_q[$];
   int   m_fail;
   int   m_idle;
   bit   m_to;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit         card;
      bit         kv;
      logic [3:0] dig;
      bit         ent;
      bit         clr;
      bit         se;
      bit         unl;
      logic [6:0] exp;
   } vec_t;

   vec_t tv[$];

   // {pin_correct, pin_wrong, card_locked, timeout, attempts_left, busy}
   function automatic logic [6:0] o(
      input bit pc, input bit pw, input bit cl,
      input bit tmo, input int att, input bit bz);
      return {pc, pw, cl, tmo, 2'(att), bz};
   endfunction

   function automatic logic [6:0] dut_out();
      return {bus.pin_correct, bus.pin_wrong,
              bus.card_locked, bus.timeout,
              bus.attempts_left, bus.busy};
   endfunction

   function automatic logic [6:0] exp_out();
      return o(m_ph == M_GRANTED, m_ph == M_DENIED,
               m_ph == M_LOCKED, m_to, MA - m_fail,
               m_ph == M_COLLECT || m_ph == M_CHECK);
   endfunction

   function automatic int q_value();
      int v = 0;
      foreach (m_q[i]) v = v * 16 + m_q[i];
      return v;
   endfunction

   task automatic model_reset();
      m_ph = M_IDLE;
      m_q.delete();
      m_fail = 0;
      m_idle = 0;
      m_to = 1'b0;
   endtask

   task automatic model_edge(
      input bit card, input bit kv, input logic [3:0] dig,
      input bit ent, input bit clr, input bit se,
      input bit unl, input logic [15:0] pin);
      m_to = 1'b0;
      case (m_ph)
         M_IDLE: begin
            m_q.delete();
            m_idle = 0;
            if (card) m_ph = M_COLLECT;
         end
         M_COLLECT: begin
            if (se) begin
               m_ph = M_IDLE;
               m_q.delete();
            end else if (clr) begin
               m_q.delete();
               m_idle = 0;
            end else if (ent) begin
               m_idle = 0;
               m_ph = (m_q.size() == PD) ? M_CHECK : M_DENIED;
            end else if (kv && dig <= 9 && m_q.size() < PD) begin
               m_q.push_back(int'(dig));
               m_idle = 0;
            end else if (m_idle >= TO - 1) begin
               m_ph = M_IDLE;
               m_to = 1'b1;
               m_q.delete();
            end else begin
               m_idle++;
            end
         end
         M_CHECK: begin
            if (se) begin
               m_ph = M_IDLE;
               m_q.delete();
            end else if (q_value() == int'(pin)) begin
               m_ph = M_GRANTED;
               m_fail = 0;
            end else begin
               m_ph = M_DENIED;
            end
         end
         M_GRANTED: if (se) m_ph = M_IDLE;
         M_DENIED: begin
            if (m_fail < MA) m_fail++;
            m_q.delete();
            m_idle = 0;
            if (m_fail == MA) m_ph = M_LOCKED;
            else if (se)      m_ph = M_IDLE;
            else              m_ph = M_COLLECT;
         end
         M_LOCKED: begin
            if (unl) begin
               m_fail = 0;
               m_ph = M_IDLE;
            end
         end
         default: m_ph = M_IDLE;
      endcase
   endtask

   task automatic check(input string name,
                        input logic [6:0] got,
                        input logic [6:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   task automatic check_int(input string name,
                            input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic cyc(
      input bit card, input bit kv, input logic [3:0] dig,
      input bit ent, input bit clr, input bit se, input bit unl);
      bus.card_inserted = card;
      bus.key_valid     = kv;
      bus.key_digit     = dig;
      bus.key_enter     = ent;
      bus.key_clear     = clr;
      bus.session_end   = se;
      bus.admin_unlock  = unl;
      @(posedge clk);
      model_edge(card, kv, dig, ent, clr, se, unl, bus.stored_pin);
      #1;
      bus.card_inserted = 1'b0;
      bus.key_valid     = 1'b0;
      bus.key_digit     = 4'd0;
      bus.key_enter     = 1'b0;
      bus.key_clear     = 1'b0;
      bus.session_end   = 1'b0;
      bus.admin_unlock  = 1'b0;
      check($sformatf("model@%0t", $time), dut_out(), exp_out());
   endtask

   task automatic idle();  cyc(0, 0, 4'd0, 0, 0, 0, 0); endtask
   task automatic card();  cyc(1, 0, 4'd0, 0, 0, 0, 0); endtask
   task automatic enter(); cyc(0, 0, 4'd0, 1, 0, 0, 0); endtask
   task automatic clr();   cyc(0, 0, 4'd0, 0, 1, 0, 0); endtask
   task automatic s_end(); cyc(0, 0, 4'd0, 0, 0, 1, 0); endtask
   task automatic unlk();  cyc(0, 0, 4'd0, 0, 0, 0, 1); endtask
   task automatic key(input int d);
      cyc(0, 1, 4'(d), 0, 0, 0, 0);
   endtask
   task automatic pin1234();
      for (int i = 1; i <= 4; i++) key(i);
   endtask

   task automatic add(
      input bit cd, input bit kv, input int dig, input bit ent,
      input bit cl, input bit se, input logic [6:0] exp);
      tv.push_back('{cd, kv, 4'(dig), ent, cl, se, 1'b0, exp});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not end, limit %0d ns", 2_000_000);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      bus.card_inserted = 1'b0;
      bus.key_valid     = 1'b0;
      bus.key_digit     = 4'd0;
      bus.key_enter     = 1'b0;
      bus.key_clear     = 1'b0;
      bus.session_end   = 1'b0;
      bus.admin_unlock  = 1'b0;
      bus.stored_pin    = 16'h1234;
      model_reset();
      #1;
      check("reset", dut_out(), o(0, 0, 0, 0, 3, 0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // correct PIN, then one wrong entry followed by a correct one
      add(1, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 3, 1));
      for (int d = 1; d <= 4; d++) add(0, 1, d, 0, 0, 0, o(0, 0, 0, 0, 3, 1));
      add(0, 0, 0, 1, 0, 0, o(0, 0, 0, 0, 3, 1));
      add(0, 0, 0, 0, 0, 0, o(1, 0, 0, 0, 3, 0));
      add(0, 0, 0, 0, 0, 0, o(1, 0, 0, 0, 3, 0));
      add(0, 0, 0, 0, 0, 1, o(0, 0, 0, 0, 3, 0));
      add(1, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 3, 1));
      add(0, 1, 1, 0, 0, 0, o(0, 0, 0, 0, 3, 1));
      add(0, 1, 2, 0, 0, 0, o(0, 0, 0, 0, 3, 1));
      add(0, 1, 3, 0, 0, 0, o(0, 0, 0, 0, 3, 1));
      add(0, 1, 5, 0, 0, 0, o(0, 0, 0, 0, 3, 1));
      add(0, 0, 0, 1, 0, 0, o(0, 0, 0, 0, 3, 1));
      add(0, 0, 0, 0, 0, 0, o(0, 1, 0, 0, 3, 0));
      add(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 2, 1));
      for (int d = 1; d <= 4; d++) add(0, 1, d, 0, 0, 0, o(0, 0, 0, 0, 2, 1));
      add(0, 0, 0, 1, 0, 0, o(0, 0, 0, 0, 2, 1));
      add(0, 0, 0, 0, 0, 0, o(1, 0, 0, 0, 3, 0));
      add(0, 0, 0, 0, 0, 1, o(0, 0, 0, 0, 3, 0));

      foreach (tv[i]) begin
         cyc(tv[i].card, tv[i].kv, tv[i].dig, tv[i].ent,
             tv[i].clr, tv[i].se, tv[i].unl);
         check($sformatf("vec%0d", i), dut_out(), tv[i].exp);
      end

      // lockout after three wrong entries
      card();
      for (int a = 0; a < 3; a++) begin
         for (int k = 0; k < 4; k++) key(9);
         enter();
         idle();
         check($sformatf("deny%0d", a), dut_out(), o(0, 1, 0, 0, 3 - a, 0));
         idle();
         if (a < 2)
            check($sformatf("retry%0d", a), dut_out(), o(0, 0, 0, 0, 2 - a, 1));
         else
            check("locked", dut_out(), o(0, 0, 1, 0, 0, 0));
      end
      pin1234();
      enter();
      idle();
      check("locked_pin", dut_out(), o(0, 0, 1, 0, 0, 0));
      s_end();
      check("locked_se", dut_out(), o(0, 0, 1, 0, 0, 0));
      unlk();
      check("unlock", dut_out(), o(0, 0, 0, 0, 3, 0));

      // clear, invalid digit, short entry
      card();
      key(1);
      key(2);
      clr();
      key(10);
      pin1234();
      enter();
      idle();
      check("clear_ok", dut_out(), o(1, 0, 0, 0, 3, 0));
      s_end();
      card();
      key(1);
      key(2);
      key(3);
      enter();
      check("short_deny", dut_out(), o(0, 1, 0, 0, 3, 0));
      idle();
      check("short_after", dut_out(), o(0, 0, 0, 0, 2, 1));
      s_end();
      check("se_keeps", dut_out(), o(0, 0, 0, 0, 2, 0));

      // inactivity timeout
      card();
      key(1);
      n = 0;
      while (!bus.timeout && n < 40) begin
         idle();
         n++;
      end
      check_int("timeout_lat", n, 16);
      check("timeout_out", dut_out(), o(0, 0, 0, 1, 2, 0));
      idle();
      check("timeout_end", dut_out(), o(0, 0, 0, 0, 2, 0));

      // asynchronous reset mid-entry
      card();
      key(1);
      key(2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      check("async_rst", dut_out(), o(0, 0, 0, 0, 3, 0));
      @(negedge clk);
      rst = 1'b0;
      card();
      pin1234();
      enter();
      idle();
      check("after_rst", dut_out(), o(1, 0, 0, 0, 3, 0));
      s_end();

      // random traffic against the model
      for (int c = 0; c < 4000; c++) begin
         logic [3:0] dg;
         if (c % 500 == 0)
            bus.stored_pin = {4'($urandom_range(1, 2)),
                              4'($urandom_range(1, 2)),
                              4'($urandom_range(1, 2)),
                              4'($urandom_range(1, 2))};
         if (c % 400 == 200) begin
            for (int k = 0; k < 20; k++) idle();
         end
         dg = ($urandom_range(0, 9) == 0)
            ? 4'($urandom_range(0, 15))
            : 4'($urandom_range(1, 2));
         cyc($urandom_range(0, 9) == 0,
             $urandom_range(0, 1) == 0,
             dg,
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 29) == 0,
             $urandom_range(0, 39) == 0,
             $urandom_range(0, 29) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/atm_pin_entry.md
Name: atm_pin_entry

Overview:
Upstream stage of atm_fsm. Collects keypad digits after card insertion and compares them against the card's stored PIN. Produces the `pin_correct` level that atm_fsm consumes. Enforces a retry limit with card lockout, and an inactivity timeout.

Parameters:
PIN_DIGITS, 4, number of BCD digits in a PIN
MAX_ATTEMPTS, 3, failed entries before lockout
TIMEOUT_CYCLES, 1000, idle cycles in entry before the session aborts

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
card_inserted  in  1  card present; a level or pulse starts a session
stored_pin  in  4*PIN_DIGITS  reference PIN, BCD, most significant digit first; sampled in CHECK
key_valid  in  1  one-cycle strobe, key_digit is valid
key_digit  in  4  BCD digit; values 10..15 are ignored
key_enter  in  1  one-cycle strobe, submit the PIN
key_clear  in  1  one-cycle strobe, discard the digits entered so far
session_end  in  1  one-cycle pulse from downstream: transaction done or card ejected
admin_unlock  in  1  one-cycle pulse, leaves LOCKED
pin_correct  out  1  held high in GRANTED
pin_wrong  out  1  one-cycle pulse per failed attempt
card_locked  out  1  high in LOCKED
timeout  out  1  one-cycle pulse on inactivity abort
attempts_left  out  2  MAX_ATTEMPTS minus the fail count
busy  out  1  high in COLLECT or CHECK

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - digit buffer = 0, digit count = 0, fail count = 0, timer = 0
  - all 1-bit outputs = 0
  - attempts_left = MAX_ATTEMPTS
  - A reset mid-operation aborts immediately. No partial state survives.
- IDLE:
  - card_inserted = 1 -> COLLECT. Buffer, count and timer are cleared.
  - All key strobes are ignored.
- COLLECT. Input priority per cycle is key_clear > key_enter > key_valid.
  - key_clear: count = 0, buffer = 0.
  - key_enter with count == PIN_DIGITS -> CHECK.
  - key_enter with count < PIN_DIGITS -> DENIED (counts as a failed attempt).
  - key_valid with digit <= 9 and count < PIN_DIGITS: buffer = {buffer[low bits], digit}, count++.
  - key_valid with digit > 9, or with count == PIN_DIGITS: ignored. No state change.
  - Timer:
    - Any accepted strobe (clear, enter, or an accepted digit) resets the timer. Otherwise it increments each cycle.
    - When the timer reaches TIMEOUT_CYCLES-1: go to IDLE, pulse timeout for 1 cycle, clear the buffer. The fail count is kept.
- CHECK: a single cycle. buffer == stored_pin -> GRANTED, else -> DENIED.
- Latency: enter sampled at edge N -> state CHECK after N -> pin_correct = 1 after edge N+1.
- GRANTED:
  - pin_correct = 1, fail count cleared.
  - Held until session_end -> IDLE.
  - card_inserted and key strobes are ignored.
- DENIED: a single cycle.
  - pin_wrong = 1 for this cycle, fail count++.
  - New count == MAX_ATTEMPTS -> LOCKED.
  - Otherwise -> COLLECT with buffer, count and timer cleared.
- LOCKED:
  - card_locked = 1, attempts_left = 0.
  - Ignores every input except admin_unlock, which sets fail count = 0 and goes to IDLE.
  - session_end does not unlock.
- session_end in COLLECT, CHECK or DENIED: -> IDLE, buffer cleared, fail count kept. Ejecting the card does not reset the retry budget.
- Outputs are registered, or decoded from registered state only. No combinational paths from inputs to outputs.
- Widths:
  - Digit counter: $clog2(PIN_DIGITS+1) bits.
  - Timer: $clog2(TIMEOUT_CYCLES) bits, saturating. It never wraps.
  - Fail count saturates at MAX_ATTEMPTS.

Decomposition:
- Package atm_pkg holds:
  - the state enum pin_state_t: IDLE, COLLECT, CHECK, GRANTED, DENIED, LOCKED
  - BCD_MAX = 9
  - default PIN_DIGITS and MAX_ATTEMPTS constants, shared with atm_fsm.
- One natural sub-module, atm_pin_buffer. It owns the digit shift register and counter, and takes clear and push inputs. It outputs the buffer, count and a full flag.
- The FSM, timer and fail counter stay in atm_pin_entry.

Test Plan:
1. Correct PIN, stored_pin = 16'h1234: card_inserted pulse, digits 1,2,3,4, then enter. Required: pin_correct = 1 two cycles after enter and held. After session_end: pin_correct = 0, attempts_left = 3.
2. One wrong entry, stored_pin = 16'h1234: enter 1,2,3,5 then enter. Required: pin_wrong pulses once, attempts_left = 2, busy = 1. Then 1,2,3,4 with enter: pin_correct = 1, attempts_left = 3.
3. Lockout: three wrong entries (9,9,9,9 each). Required: card_locked = 1 after the third pin_wrong, and a subsequent correct PIN is ignored. admin_unlock returns to IDLE with card_locked = 0 and attempts_left = 3.
4. Clear and invalid digits: digits 1,2 then key_clear; digit 4'hA; then 1,2,3,4 with enter. Required: pin_correct = 1. Enter after only 3 digits gives pin_wrong with attempts_left decremented.
5. Timeout, with TIMEOUT_CYCLES = 16 in the bench: insert card, key 1, then idle. Required: timeout pulses 16 cycles after the last key, state returns to IDLE, attempts_left is unchanged.
6. Async reset mid-entry: assert rst between clock edges after two digits. Required: outputs clear immediately, without waiting for a clock edge. After release, a fresh 1,2,3,4 entry is accepted.
